// File: rtl/wb_cpu_bridge.sv
// CPU native memory port to Wishbone classic single-beat master bridge.
// Optional access watchdog compiled in with `define WB_BRIDGE_TIMEOUT_EN.
module wb_cpu_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  output logic        o_bus_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_bus_err;
  logic [31:0] r_rdata;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] r_cnt;
  logic w_unused_addr;
  assign w_unused_addr = ^i_mem_addr[1:0];
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES >= 2) ^ (|ERR_DATA) ^ (^i_mem_addr[1:0]);
`endif

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_bus_err <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_adr     <= 32'h0000_0000;
      r_dat     <= 32'h0000_0000;
      r_sel     <= 4'h0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_ready   <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mem_valid) begin
            r_adr   <= {i_mem_addr[31:2], 2'b00};
            r_dat   <= i_mem_wdata;
            r_we    <= (i_mem_wstrb != 4'h0);
            r_sel   <= (i_mem_wstrb != 4'h0) ? i_mem_wstrb : 4'hF;
            r_cyc   <= 1'b1;
            r_state <= S_BUS;
`ifdef WB_BRIDGE_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUS: begin
          // Ack has priority over a watchdog expiry landing on the same edge.
          if (i_wb_ack) begin
            if (!r_we) begin
              r_rdata <= i_wb_dat;
            end
            r_cyc   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end
`ifdef WB_BRIDGE_TIMEOUT_EN
          else if (r_cnt == CNT_MAX) begin
            r_rdata   <= ERR_DATA;
            r_cyc     <= 1'b0;
            r_ready   <= 1'b1;
            r_bus_err <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
`else
          else begin
            r_state <= S_BUS;
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_ready = r_ready;
  assign o_mem_rdata = r_rdata;
  assign o_bus_err   = r_bus_err;
  assign o_wb_adr    = r_adr;
  assign o_wb_dat    = r_dat;
  assign o_wb_sel    = r_sel;
  assign o_wb_we     = r_we;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_cyc;

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Scoreboard bench for wb_cpu_bridge with a configurable-latency Wishbone slave.
module tb_wb_cpu_bridge;

  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        ready, bus_err, wb_we, wb_cyc, wb_stb;
  logic [31:0] rdata, wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        ack = 1'b0;
  logic [31:0] slv_data = 32'h0;
  int          slv_ack_lat = 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb_q[$];
  logic [31:0] last_rdata = 32'h0;

  wb_cpu_bridge #(.TIMEOUT_CYCLES(16), .ERR_DATA(ERR)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_mem_valid(valid), .i_mem_addr(addr), .i_mem_wdata(wdata), .i_mem_wstrb(wstrb),
    .o_mem_ready(ready), .o_mem_rdata(rdata), .o_bus_err(bus_err),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .i_wb_ack(ack), .i_wb_dat(slv_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave: ack rises once stb has been seen high for slv_ack_lat edges; stays while stb stays.
  initial begin
    int cnt;
    logic s;
    cnt = 0;
    forever begin
      @(negedge clk);
      s = wb_stb;
      @(posedge clk);
      #1;
      cnt = s ? cnt + 1 : 0;
      ack = (cnt >= slv_ack_lat);
    end
  end

  // Output monitor: pops the scoreboard on every ready pulse.
  initial begin
    logic prev_ready;
    logic [32:0] e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check_val("unexpected_ready", ready, 0);
      end else if (ready) begin
        e = sb_q.pop_front();
        check_val("ready_one_cycle", prev_ready, 0);
        check_val("rdata", rdata, e[31:0]);
        check_val("bus_err", bus_err, e[32]);
        check_val("cyc_at_ready", wb_cyc, 0);
      end
      if (!ready) check_val("err_without_ready", bus_err, 0);
      if (prev_ready) check_val("stb_gap", wb_stb, 0);
      prev_ready = ready;
    end
  end

  task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] sd, input int lat, input int exp_stb,
                            input logic exp_err);
    int n, stb_n;
    logic [31:0] exp_rd, exp_adr;
    logic [3:0]  exp_sel;
    exp_rd  = exp_err ? ERR : ((ws == 4'h0) ? sd : last_rdata);
    exp_adr = {a[31:2], 2'b00};
    exp_sel = (ws == 4'h0) ? 4'hF : ws;
    last_rdata = exp_rd;
    sb_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    slv_ack_lat = lat;
    slv_data = sd;
    valid = 1'b1; addr = a; wdata = wd; wstrb = ws;
    n = 0; stb_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (wb_stb) stb_n++;
      if (n == 1) begin
        check_val("wb_adr", wb_adr, exp_adr);
        check_val("wb_sel", wb_sel, exp_sel);
        check_val("wb_we", wb_we, ws != 4'h0);
        check_val("wb_dat", wb_dat, wd);
        check_val("wb_cyc_stb", {wb_cyc, wb_stb}, 2'b11);
      end
      if (n == 2) begin
        // Request inputs wander mid-access; the bridge must keep its latched copy.
        addr = ~a; wdata = ~wd; wstrb = ~ws;
      end
    end while (!ready && n < 2000);
    valid = 1'b0;
    check_val("latency", n, exp_stb + 1);
    check_val("stb_cycles", stb_n, exp_stb);
    check_val("adr_hold", wb_adr, exp_adr);
    check_val("sel_hold", wb_sel, exp_sel);
  endtask

  task automatic async_reset_mid_cycle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
    check_val("rst_ready", ready, 0);
    check_val("rst_adr", wb_adr, 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    valid = 1'b0;
    last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc_n, err_n;
    repeat (3) @(negedge clk);
    check_val("reset_ctrl", {ready, bus_err, wb_cyc, wb_stb, wb_we}, 5'b0);
    check_val("reset_data", {wb_adr, rdata}, 64'h0);
    check_val("reset_sel", wb_sel, 4'h0);
    rst = 1'b0;

    cpu_access(32'h0000_0103, 32'h1111_2222, 4'h0, 32'h8000_0005, 1, 2, 1'b0);
    cpu_access(32'h0000_0104, 32'h0000_00AB, 4'b0001, 32'h5555_AAAA, 1, 2, 1'b0);
    cpu_access(32'h0000_0200, 32'h0, 4'h0, 32'h1234_5678, 1, 2, 1'b0);
    cpu_access(32'h0000_020E, 32'hDEAD_BEEF, 4'b1100, 32'h0, 1, 2, 1'b0);
    cpu_access(32'h0000_03FF, 32'h0, 4'h0, 32'h0F0F_3C3C, 1, 2, 1'b0);
    cpu_access(32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_0016, 15, 16, 1'b0);

`ifdef WB_BRIDGE_TIMEOUT_EN
    cpu_access(32'h0000_0600, 32'h0, 4'h0, 32'h7777_7777, 1000000, 16, 1'b1);
    cpu_access(32'h0000_0604, 32'h0, 4'h0, 32'h2468_ACE0, 2, 3, 1'b0);
`else
    slv_ack_lat = 1000000;
    @(negedge clk);
    valid = 1'b1; addr = 32'h0000_0600; wstrb = 4'h0;
    cyc_n = 0; err_n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (wb_cyc) cyc_n++;
      if (bus_err) err_n++;
    end
    check_val("noto_cyc_cycles", cyc_n, 1000);
    check_val("noto_err_cycles", err_n, 0);
    async_reset_mid_cycle();
`endif

    slv_ack_lat = 1000000;
    @(negedge clk);
    valid = 1'b1; addr = 32'h0000_0500; wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check_val("pre_rst_cyc", wb_cyc, 1);
    async_reset_mid_cycle();
    repeat (3) @(negedge clk);
    cpu_access(32'h0000_0710, 32'h0, 4'h0, 32'h0BAD_F00D, 1, 2, 1'b0);
    repeat (4) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_cpu_bridge.md
# wb_cpu_bridge

Wishbone classic master bridge between the CPU native memory port (valid/ready, byte-strobe writes) and the SoC Wishbone bus feeding peripherals such as the timer. Each CPU access becomes one single-beat Wishbone cycle. A three-state FSM registers the request, waits for the slave acknowledge, and returns a one-cycle ready pulse with read data. An optional watchdog terminates accesses that are never acknowledged.

## Interface
- TIMEOUT_CYCLES, 16: maximum BUS-state cycles before forced termination (only with timeout compiled in); legal range ≥ 2.
- ERR_DATA, 32'hFFFF_FFFF: read data returned on a timed-out access.

Ports:
- i_wb_clk  in  1  single clock for the block.
- i_wb_rst  in  1  reset, asynchronous, active-high.
- i_mem_valid  in  1  CPU request; held high until o_mem_ready is seen.
- i_mem_addr  in  32  byte address.
- i_mem_wdata  in  32  write data.
- i_mem_wstrb  in  4  byte strobes; 4'h0 means read.
- o_mem_ready  out  1  one-cycle completion pulse.
- o_mem_rdata  out  32  read data, valid while o_mem_ready is high.
- o_bus_err  out  1  one-cycle pulse with o_mem_ready on a timed-out access.
- o_wb_adr  out  32  word address, i.e. {i_mem_addr[31:2], 2'b00}.
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  byte select.
- o_wb_we  out  1  write enable.
- o_wb_cyc  out  1  cycle.
- o_wb_stb  out  1  strobe, always equal to o_wb_cyc.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_dat  in  32  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE, i_mem_valid=1 at an edge:
  - latch adr, dat and we = (i_mem_wstrb != 0).
  - sel = i_mem_wstrb for writes, 4'hF for reads.
  - go to BUS; cyc/stb = 1.
- BUS, i_wb_ack=1 at an edge:
  - capture i_wb_dat into o_mem_rdata (reads only; writes leave o_mem_rdata unchanged).
  - cyc/stb = 0, o_mem_ready = 1; go to RESP.
- RESP: unconditionally go to IDLE; o_mem_ready = 0. This guarantees at least one cycle with stb low between transactions.
- i_wb_ack is ignored outside BUS, which absorbs the trailing extra ack of registered-ack slaves.
- o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we stay stable for the whole BUS state and hold their values afterwards.
- i_mem_* changes while not in IDLE are ignored.
- Reset, asynchronous and taking effect mid-transfer:
  - state = IDLE.
  - cyc, stb, we, o_mem_ready, o_bus_err = 0.
  - adr, dat, rdata = 0; sel = 4'h0.
  - timeout counter = 0.
  - An in-flight access is abandoned with no ready pulse.

## Timing
- Registered-ack slave (ack one edge after stb): i_mem_valid sampled at edge 0 → stb high after edge 0 → ack high after edge 1 → o_mem_ready high after edge 2. That is a 3-cycle request-to-ready latency.
- Minimum latency (slave with combinational ack): 2 cycles.
- Back-to-back accesses: minimum 4 cycles per access with a registered-ack slave (IDLE, BUS, BUS, RESP).
- Timeout counter:
  - cleared on entry to BUS; width $clog2(TIMEOUT_CYCLES).
  - increments at each BUS edge without ack.
  - At an edge where count == TIMEOUT_CYCLES-1 and no ack: go to RESP with o_mem_ready=1, o_bus_err=1, o_mem_rdata=ERR_DATA, cyc/stb=0.
  - So BUS lasts at most TIMEOUT_CYCLES cycles.
  - Ack and timeout at the same edge: ack wins, o_bus_err=0.

## Configuration
- WB_BRIDGE_TIMEOUT_EN defined:
  - timeout counter, o_bus_err logic and ERR_DATA path are compiled in, as described above.
- Not defined:
  - no counter is built; BUS waits indefinitely for ack.
  - o_bus_err is tied to 0; TIMEOUT_CYCLES and ERR_DATA are unused.

## Test plan
- Read, registered-ack slave returning 32'h8000_0005: i_mem_addr=32'h0000_0103, wstrb=0 → o_wb_adr=32'h0000_0100, sel=4'hF, we=0. o_mem_ready is high exactly one cycle, 3 cycles after valid, with o_mem_rdata=32'h8000_0005 and o_bus_err=0.
- Byte write: addr=32'h0000_0104, wdata=32'h0000_00AB, wstrb=4'b0001 → sel=4'b0001, we=1, dat=32'h0000_00AB. The slave's second (trailing) ack produces no second ready pulse.
- Back-to-back: i_mem_valid re-asserted the cycle after ready → stb low for ≥1 cycle between cycles; both accesses complete with correct data.
- Timeout (macro on, TIMEOUT_CYCLES=16, slave never acks) → stb high exactly 16 cycles, then o_mem_ready=o_bus_err=1 for one cycle with o_mem_rdata=32'hFFFF_FFFF. Repeat with the macro off → cyc stays high for 1000 cycles and o_bus_err stays 0.
- Ack arriving in the 16th BUS cycle → normal completion with slave data, o_bus_err=0.
- Assert i_wb_rst asynchronously mid-BUS → cyc/stb drop before the next clock edge with no ready pulse. After release, a new read completes normally.
